// File: rtl/dmem_sized_if.sv
// Bus bundle for the sized data-memory controller: request side driven by the
// pipeline (master), completion side driven by the memory (slave).
interface dmem_sized_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_sized_ctrl.sv
// Byte-addressable little-endian data memory for the MEM stage with byte/half/
// word accesses, sign/zero extension, misalignment detection and a programmable
// access latency behind a req/ready/rvalid handshake. One access in flight.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN -- when defined, addresses at or
// above DEPTH_BYTES complete with err_o instead of aliasing modulo DEPTH_BYTES.
module dmem_sized_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dmem_sized_if.slave  bus
);
  localparam int         IDX_W    = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              ready_q;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              err_pend;
  logic              load_pend;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ldata_pend;

  logic [7:0]        mem [DEPTH_BYTES];

  logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
  logic [31:0]       raw_word;
  logic              misaligned;
  logic              oob;
  logic              access_err;
  logic              accept;
  logic              fire;
  logic              wr_en;

  // Extend a little-endian raw word to 32 bits according to access size.
  function automatic logic [31:0] extend_load(input logic [1:0] size,
                                              input logic zext,
                                              input logic [31:0] raw);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    b_s = raw[7:0];
    h_s = raw[15:0];
    w_s = '0;
    extend_load = raw;
    case (size)
      2'b00: begin
        w_s = b_s;
        extend_load = zext ? {24'd0, raw[7:0]} : w_s;
      end
      2'b01: begin
        w_s = h_s;
        extend_load = zext ? {16'd0, raw[15:0]} : w_s;
      end
      default: extend_load = raw;
    endcase
  endfunction

  assign idx0     = addr_q[IDX_W-1:0];
  assign idx1     = idx0 + IDX_W'(1);
  assign idx2     = idx0 + IDX_W'(2);
  assign idx3     = idx0 + IDX_W'(3);
  assign raw_word = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};

  // Misalignment also covers the illegal size encoding.
  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      default: misaligned = 1'b1;
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |addr_q[ADDR_W-1:IDX_W];
`else
  // Upper address bits alias away when bounds checking is off.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];
  assign oob = 1'b0;
`endif

  assign access_err = misaligned | oob;
  assign accept     = (state == IDLE) && bus.req_i && ready_q;
  assign fire       = (state == BUSY) && (cnt == 4'd0);
  assign wr_en      = fire && we_q && !access_err;

  // Control FSM: accept, count down the latency, then signal completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      err_pend  <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= CNT_INIT;
            ready_q <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            err_pend  <= access_err;
            load_pend <= !we_q && !access_err;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          rvalid_q <= 1'b1;
          err_q    <= err_pend;
          if (load_pend) rdata_q <= ldata_pend;
          ready_q  <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Request capture at acceptance and load-data capture at the access edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= bus.we_i;
      size_q  <= bus.size_i;
      uns_q   <= bus.unsigned_i;
      addr_q  <= bus.addr_i;
      wdata_q <= bus.wdata_i;
    end
    if (fire) ldata_pend <= extend_load(size_q, uns_q, raw_word);
  end

  // Byte-lane store into the little-endian array.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[idx0] <= wdata_q[7:0];
      if (size_q != 2'b00) mem[idx1] <= wdata_q[15:8];
      if (size_q == 2'b10) begin
        mem[idx2] <= wdata_q[23:16];
        mem[idx3] <= wdata_q[31:24];
      end
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Bench for dmem_sized_ctrl: two instances (latency 1 and latency 4) checked
// every cycle against a byte-array model, plus literal expectations.
module tb_dmem_sized_ctrl;
  localparam int DEPTH = 1024;
  localparam int LAT0  = 1;
  localparam int LAT1  = 4;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Drive and observe arrays, one entry per DUT.
  logic        req [2];
  logic        we  [2];
  logic [1:0]  sz  [2];
  logic        uns [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic        ready_s [2];
  logic        rvalid_s[2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];

  dmem_sized_if #(.ADDR_W(32)) bus0 ();
  dmem_sized_if #(.ADDR_W(32)) bus1 ();

  assign bus0.req_i = req[0]; assign bus0.we_i = we[0]; assign bus0.size_i = sz[0];
  assign bus0.unsigned_i = uns[0]; assign bus0.addr_i = adr[0]; assign bus0.wdata_i = wd[0];
  assign bus1.req_i = req[1]; assign bus1.we_i = we[1]; assign bus1.size_i = sz[1];
  assign bus1.unsigned_i = uns[1]; assign bus1.addr_i = adr[1]; assign bus1.wdata_i = wd[1];
  assign ready_s[0] = bus0.ready_o; assign rvalid_s[0] = bus0.rvalid_o;
  assign rdata_s[0] = bus0.rdata_o; assign err_s[0] = bus0.err_o;
  assign ready_s[1] = bus1.ready_o; assign rvalid_s[1] = bus1.rvalid_o;
  assign rdata_s[1] = bus1.rdata_o; assign err_s[1] = bus1.err_o;

  dmem_sized_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus0.slave));
  dmem_sized_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Model state.
  logic [7:0]  mmem [2][DEPTH];
  logic [31:0] mrdata [2];
  int          acc_cnt [2];
  int          done_cnt[2];
  int          acc_cyc [2];
  int          due     [2];
  logic        p_we [2];
  logic [1:0]  p_sz [2];
  logic        p_uns[2];
  logic [31:0] p_adr[2];
  logic [31:0] p_wd [2];
  int          last_rv_cyc[2];
  logic        last_err  [2];
  logic [31:0] last_rdata[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Apply the pending access of DUT d to the model; returns expected err.
  task automatic model_complete(input int d, output bit e);
    int     n;
    longint a;
    longint v;
    n = (p_sz[d] == 2'd0) ? 1 : (p_sz[d] == 2'd1) ? 2 : 4;
    a = longint'(p_adr[d]);
    e = (p_sz[d] == 2'd3) || ((a % n) != 0);
    if (BOUNDS && a >= DEPTH) e = 1'b1;
    if (!e) begin
      if (p_we[d]) begin
        for (int i = 0; i < n; i++) mmem[d][(a + i) % DEPTH] = p_wd[d][8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(mmem[d][(a + i) % DEPTH]) << (8 * i));
        if (!p_uns[d] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        mrdata[d] = v[31:0];
      end
    end
  endtask

  // Acceptance tracker.
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (req[d] && ready_s[d]) begin
          p_we[d]  = we[d];  p_sz[d] = sz[d]; p_uns[d] = uns[d];
          p_adr[d] = adr[d]; p_wd[d] = wd[d];
          acc_cyc[d] = cyc;
          due[d] = cyc + lat_of(d) + 1;
          acc_cnt[d]++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit due_now;
    bit e;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        due_now = 1'b0;
        e = 1'b0;
        if (!rst_n) begin
          done_cnt[d] = acc_cnt[d];
          mrdata[d] = 32'd0;
        end else if (acc_cnt[d] != done_cnt[d] && cyc == due[d]) begin
          due_now = 1'b1;
          model_complete(d, e);
          done_cnt[d] = acc_cnt[d];
          last_rv_cyc[d] = cyc;
          last_err[d] = err_s[d];
          last_rdata[d] = rdata_s[d];
        end
        chk($sformatf("rvalid%0d@%0d", d, cyc), {31'd0, rvalid_s[d]}, {31'd0, due_now});
        chk($sformatf("err%0d@%0d", d, cyc), {31'd0, err_s[d]}, {31'd0, e});
        chk($sformatf("rdata%0d@%0d", d, cyc), rdata_s[d], mrdata[d]);
        chk($sformatf("ready%0d@%0d", d, cyc), {31'd0, ready_s[d]},
            {31'd0, (acc_cnt[d] == done_cnt[d])});
      end
    end
  end

  // Present a request and hold it until accepted; optionally keep req high.
  task automatic do_op(input int d, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] data, input bit keep);
    int start;
    int n;
    @(negedge clk);
    start = acc_cnt[d];
    we[d] = w; sz[d] = s; uns[d] = u; adr[d] = a; wd[d] = data; req[d] = 1'b1;
    n = 0;
    while (acc_cnt[d] == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt[d] == start) chk($sformatf("accept_timeout%0d", d), 32'd0, 32'd1);
    if (!keep) req[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (acc_cnt[d] != done_cnt[d] && n < 100);
    if (acc_cnt[d] != done_cnt[d]) chk($sformatf("done_timeout%0d", d), 32'd0, 32'd1);
  endtask

  task automatic op(input int d, input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] data);
    do_op(d, w, s, u, a, data, 1'b0);
    wait_done(d);
  endtask

  int acc_hist[4];
  int done_base;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; sz[d] = 0; uns[d] = 0; adr[d] = 0; wd[d] = 0;
      mrdata[d] = 0; acc_cnt[d] = 0; done_cnt[d] = 0; acc_cyc[d] = 0; due[d] = 0;
      last_rv_cyc[d] = 0; last_err[d] = 0; last_rdata[d] = 0;
      for (int i = 0; i < DEPTH; i++) mmem[d][i] = 8'h00;
    end
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ready", {31'd0, ready_s[0]}, 32'd1);
    chk("reset_rvalid", {31'd0, rvalid_s[0]}, 32'd0);
    chk("reset_rdata", rdata_s[0], 32'd0);
    chk("reset_err", {31'd0, err_s[0]}, 32'd0);
    #19 rst_n = 1'b1;
    chk_en = 1'b1;

    // Word store then signed byte loads.
    op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    chk("st_w_err", {31'd0, last_err[0]}, 32'd0);
    op(0, 0, 2'd0, 0, 32'h10, 0);
    chk("ld_b10", last_rdata[0], 32'hFFFFFFEF);
    chk("ld_lat", last_rv_cyc[0] - acc_cyc[0], 32'd2);
    op(0, 0, 2'd0, 0, 32'h11, 0);
    chk("ld_b11", last_rdata[0], 32'hFFFFFFBE);
    op(0, 0, 2'd0, 0, 32'h13, 0);
    chk("ld_b13", last_rdata[0], 32'hFFFFFFDE);
    chk("ld_b13_err", {31'd0, last_err[0]}, 32'd0);

    // Half store, signed/unsigned half loads, neighbouring bytes intact.
    op(0, 1, 2'd2, 0, 32'h20, 32'h11223344);
    op(0, 1, 2'd1, 0, 32'h22, 32'hFFFF8001);
    op(0, 0, 2'd1, 0, 32'h22, 0);
    chk("ld_h_s", last_rdata[0], 32'hFFFF8001);
    op(0, 0, 2'd1, 1, 32'h22, 0);
    chk("ld_h_u", last_rdata[0], 32'h00008001);
    op(0, 0, 2'd2, 0, 32'h20, 0);
    chk("ld_w20", last_rdata[0], 32'h80013344);

    // Misaligned and illegal-size accesses.
    op(0, 1, 2'd2, 0, 32'h04, 32'hCAFEF00D);
    op(0, 0, 2'd2, 0, 32'h13, 0);
    chk("mis_ld_err", {31'd0, last_err[0]}, 32'd1);
    chk("mis_ld_hold", last_rdata[0], 32'h80013344);
    op(0, 1, 2'd1, 0, 32'h05, 32'h00001234);
    chk("mis_st_err", {31'd0, last_err[0]}, 32'd1);
    op(0, 0, 2'd3, 0, 32'h08, 0);
    chk("sz3_err", {31'd0, last_err[0]}, 32'd1);
    op(0, 0, 2'd2, 0, 32'h04, 0);
    chk("ld_w04", last_rdata[0], 32'hCAFEF00D);
    op(0, 0, 2'd0, 1, 32'h13, 0);
    chk("ld_bu13", last_rdata[0], 32'h000000DE);

    // Out-of-range byte store.
    op(0, 1, 2'd2, 0, 32'h000, 32'hA5A5A5A5);
    op(0, 1, 2'd0, 0, 32'h400, 32'h0000005A);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("oob_err", {31'd0, last_err[0]}, 32'd1);
`else
    chk("oob_err", {31'd0, last_err[0]}, 32'd0);
`endif
    op(0, 0, 2'd0, 1, 32'h000, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("oob_ld0", last_rdata[0], 32'h000000A5);
`else
    chk("oob_ld0", last_rdata[0], 32'h0000005A);
`endif

    // Latency 4, request held high across four back-to-back accesses.
    done_base = done_cnt[1];
    do_op(1, 1, 2'd2, 0, 32'h40, 32'h01020304, 1'b1); acc_hist[0] = acc_cyc[1];
    do_op(1, 1, 2'd2, 0, 32'h44, 32'hA0B0C0D0, 1'b1); acc_hist[1] = acc_cyc[1];
    do_op(1, 0, 2'd2, 0, 32'h40, 0, 1'b1);            acc_hist[2] = acc_cyc[1];
    do_op(1, 0, 2'd2, 0, 32'h44, 0, 1'b0);            acc_hist[3] = acc_cyc[1];
    wait_done(1);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acc_hist[i] - acc_hist[i-1], 32'd6);
    chk("b2b_count", done_cnt[1] - done_base, 32'd4);
    chk("b2b_last", last_rdata[1], 32'hA0B0C0D0);

    // Reset during a store's busy phase aborts it.
    do_op(1, 1, 2'd2, 0, 32'h40, 32'hDEADDEAD, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_s[1]}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid_s[1]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op(1, 0, 2'd2, 0, 32'h40, 0);
    chk("rst_old", last_rdata[1], 32'h01020304);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_sized_ctrl.md
Name: dmem_sized_ctrl

Overview:
- Parametrised byte-addressable little-endian data memory for the MEM stage.
- Adds byte, half and word accesses, sign/zero extension and misalignment detection.
- Programmable access latency with a req/ready/rvalid handshake, so the pipeline can stall on memory.
- Storage is an internal byte array; one access is in flight at a time.

Parameters:
- ADDR_W, 32, width of addr_i.
- DEPTH_BYTES, 1024, number of bytes; must be a power of two and at least 4.
- LATENCY, 1, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  1  access request; sampled only when ready_o=1.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00=byte, 01=half, 10=word, 11=illegal.
- unsigned_i  in  1  load extension: 1=zero-extend, 0=sign-extend.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data; the low bytes are used for byte and half stores.
- ready_o  out  1  idle; a request will be accepted this cycle.
- rvalid_o  out  1  one-cycle pulse on completion of every accepted access, loads and stores alike.
- rdata_o  out  32  load result; held until the next load completes.
- err_o  out  1  qualifies rvalid_o; access was misaligned, size=11, or out of range.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, ready_o=1, rvalid_o=0, rdata_o=0, err_o=0, latency counter=0. Memory contents are not reset.
- FSM states:
  - IDLE: on req_i&ready_o, latch we, size, unsigned, addr and wdata; load counter=LATENCY-1; go to BUSY. ready_o=0 from the next cycle.
  - BUSY: decrement the counter each cycle. When the counter reaches 0, perform the access at that edge and go to DONE.
  - DONE: rvalid_o=1 for exactly one cycle, ready_o=1, return to IDLE.
  - Result: total latency from accepting edge to rvalid_o high = LATENCY+1 edges.
- Effective byte index = latched addr mod DEPTH_BYTES (low log2(DEPTH_BYTES) bits), unless DMEM_BOUNDS_CHECK_EN is defined.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A misaligned access or size=11 completes with err_o=1, performs no write, and leaves rdata_o unchanged.
- Store: write the lowest 1/2/4 bytes of wdata into mem[a], mem[a+1], ... in little-endian order. No other byte changes.
- Load:
  - byte: rdata_o = ext(mem[a]).
  - half: rdata_o = ext({mem[a+1],mem[a]}).
  - word: rdata_o = {mem[a+3],...,mem[a]}.
  - Sign extension replicates bit 7 (byte) or bit 15 (half).
- rdata_o updates only at the DONE transition of a successful load; a store never alters it.
- req_i while ready_o=0 is ignored; no queuing. Master holds req_i and retries.
- Reset mid-access: the access is aborted, no write occurs, and no rvalid_o is issued.
- err_o is 0 whenever rvalid_o is 0.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: if addr >= DEPTH_BYTES (any upper bit set), the access completes with err_o=1, no write occurs and rdata_o is unchanged. Misalignment check still applies; err_o is 1 if either condition holds.
- Undefined: upper address bits are ignored and addresses alias modulo DEPTH_BYTES. Out-of-range never raises err_o.

Test Plan:
- LATENCY=1: store word 0xDEADBEEF at 0x10, then load byte 0x10/0x11/0x13 signed -> rdata 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFDE; rvalid_o 2 edges after each accept; err_o=0.
- Store half 0x8001 at 0x22, load half signed -> 0xFFFF8001; unsigned -> 0x00008001; word at 0x20 shows bytes 0x20,0x21 unchanged.
- Load word at 0x13 and store half at 0x05 -> each completes with rvalid_o=1, err_o=1; memory at 0x04..0x07 unchanged; rdata_o keeps its previous value.
- LATENCY=4: req_i held high continuously -> ready_o low 5 cycles per access; back-to-back accepts every 6 cycles; extra requests are not lost or duplicated.
- Assert rst_i low during BUSY of a store to 0x40 -> ready_o=1 and rvalid_o=0 immediately; a later load of 0x40 returns the old contents.
- DEPTH_BYTES=1024, store byte to 0x400:
  - with DMEM_BOUNDS_CHECK_EN -> err_o=1 and 0x000 unchanged.
  - without -> err_o=0 and load of 0x000 returns the stored byte.
